stream_accumulator: RTL
=======================

# stream_accumulator

Accumulates a packet of N-bit operands delivered over a valid/ready stream into a running sum and presents the total with carry statistics on an output valid/ready stream. Sits directly downstream of `ripple_carry_adder`: it instantiates one N-bit ripple carry adder with `cin` tied to 0, and registers the adder's `sum` and `cout` every accepted beat. It turns the combinational adder into a multi-operand, flow-controlled summing stage.

## Interface
Parameters:
- `N`, 32, operand and sum width in bits.
- `CW`, 8, width of the carry and term counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  an operand beat is presented.
- `in_ready`  out  1  the block can accept a beat.
- `in_data`  in  N  operand.
- `in_last`  in  1  this beat is the final operand of the packet.
- `out_valid`  out  1  the result is presented.
- `out_ready`  in  1  the consumer takes the result.
- `out_sum`  out  N  packet sum modulo 2^N.
- `out_carries`  out  CW  number of beats whose addition produced `cout`=1, saturating.
- `out_terms`  out  CW  number of operands in the packet, saturating.
- `out_ovf`  out  1  sticky flag: a counter saturated during this packet.

## Operation
- The clock is one domain, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Accept event: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- State machine with three states:
  - IDLE: `in_ready`=1, `out_valid`=0. On accept, load acc=`in_data`, carries=0, terms=1, ovf=0. The first beat is not added to the previous contents. Next state is HOLD if `in_last`, otherwise ACC.
  - ACC: `in_ready`=1, `out_valid`=0. On accept:
    - acc <= adder `sum` of acc + `in_data`.
    - carries += adder `cout`.
    - terms += 1.
    - If `in_last`, go to HOLD. Without an accept, all state holds.
  - HOLD: `in_ready`=0, `out_valid`=1. Outputs are frozen. On output transfer, go to IDLE.
- Saturation: a counter at 2^CW-1 stays there on a further increment, and `out_ovf` sets to 1. `out_ovf` is cleared only by an IDLE load or by reset.
- `out_sum` is the acc register directly. `out_carries` and `out_terms` are the counter registers directly. There is no output mux.
- Width rules:
  - acc is N bits and wraps modulo 2^N.
  - Carry detection uses only the adder's `cout`. `cin` is always 0.
- Boundary conditions:
  - A single-beat packet (`in_last` on the first beat) goes from IDLE to HOLD with sum=`in_data`, carries=0, terms=1.
  - `in_valid` while in HOLD is not accepted. The upstream stage must hold its beat until `in_ready` returns.
  - Reset mid-packet drops the partial sum. No output is produced for that packet.
  - While in IDLE, `out_*` keep the last result, but `out_valid`=0.

## Timing
- Reset values:
  - State: IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `out_sum`=0, `out_carries`=0, `out_terms`=0, `out_ovf`=0.
- Latency: `out_valid` rises in the cycle after the edge that accepts the `in_last` beat.
- Throughput:
  - One beat per cycle within a packet.
  - At least one bubble between packets: the HOLD cycle(s), then IDLE is re-entered before the next accept.
- A transfer in the HOLD cycle returns the block to IDLE at the next edge. `in_ready` is 1 in that following cycle.
- The adder path is combinational, from acc and `in_data` to the acc D-input. It must close in one `clk` period for the configured N.

## Test plan
- Packet {0x00000003, 0x0000000A last} with `out_ready`=1 -> `out_sum`=0x0000000D, carries=0, terms=2, ovf=0, and `out_valid` high for exactly one cycle.
- Packet {0xAAAAAAAA, 0x55555555 last} -> `out_sum`=0xFFFFFFFF, carries=0, terms=2.
- Packet {0xFFFFFFFF, 0x00000001, 0xFFFFFFFF last} -> `out_sum`=0xFFFFFFFF, carries=1, terms=3. Then a single-beat packet {0xA5A5A5A5 last} -> `out_sum`=0xA5A5A5A5, carries=0, terms=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD while `in_valid`=1 with the next packet's first beat ->
  - `out_valid` stays at 1 and `out_*` stay stable.
  - `in_ready`=0 throughout.
  - After `out_ready` pulses, the pending beat is accepted in the IDLE cycle and the new sum starts from that beat.
- Saturation: 257 beats of 0xFFFFFFFF, the last beat flagged `in_last` -> `out_sum`=0xFFFFFEFF, carries=255, terms=255, ovf=1. The next packet {0x1 last} gives ovf=0.
- Reset: assert `rst_n`=0 asynchronously after two beats of a packet -> all outputs are 0 immediately and the state is IDLE. After release, {0x5 last} gives `out_sum`=0x5, terms=1.

Source files
------------

// File: rtl/stream_accumulator.sv
// Flow-controlled multi-operand summing stage built around one ripple carry adder.
// Reports the packet sum, saturating carry/term counts and a sticky overflow flag.
module ripple_carry_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

module stream_accumulator #(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic [CW-1:0] out_carries,
  output logic [CW-1:0] out_terms,
  output logic          out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_e;

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] carries_q, carries_d;
  logic [CW-1:0] terms_q, terms_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  add_sum;
  logic          add_cout;
  logic          accept;
  logic          xfer;

  ripple_carry_adder #(
    .N(N)
  ) u_rca (
    .a   (acc_q),
    .b   (in_data),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  assign out_sum     = acc_q;
  assign out_carries = carries_q;
  assign out_terms   = terms_q;
  assign out_ovf     = ovf_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carries_d = carries_q;
    terms_d   = terms_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        // first beat replaces the previous result
        if (accept) begin
          acc_d     = in_data;
          carries_d = '0;
          terms_d   = ONE;
          ovf_d     = 1'b0;
          state_d   = in_last ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_d = add_sum;
          if (add_cout) begin
            if (carries_q == CMAX) ovf_d = 1'b1;
            else carries_d = carries_q + ONE;
          end
          if (terms_q == CMAX) ovf_d = 1'b1;
          else terms_d = terms_q + ONE;
          if (in_last) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      carries_q <= '0;
      terms_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      carries_q <= carries_d;
      terms_q   <= terms_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
